// File: rtl/pwm_breathe_pkg.sv
// Shared encodings for the breathing LED driver:
// ramp modes and ramp direction.
package pwm_breathe_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_SAW  = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One breathing channel: duty ramp engine, period-aligned shadow
// register, PWM compare and registered LED output.
module pwm_channel
    import pwm_breathe_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             en,
    input  logic             step,
    input  logic [WIDTH-1:0] cnt,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] peak,
    output logic [WIDTH-1:0] duty,
    output logic             led
);

    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    dir_e             dir_q, dir_d, dir_cur;
    mode_e            mode_q, mode_d, mode_in;
    logic             led_q, led_d;

    always_comb begin
        mode_in  = mode_e'(mode);
        duty_d   = duty_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        shadow_d = shadow_q;
        dir_cur  = dir_q;
        if (step) begin
            mode_d = mode_in;
            // A fresh triangle always starts climbing.
            if (mode_in == MODE_TRI && mode_q != MODE_TRI) begin
                dir_cur = DIR_UP;
            end
            dir_d = dir_cur;
            unique case (mode_in)
                MODE_OFF: begin
                    duty_d = ZERO;
                    dir_d  = DIR_UP;
                end
                MODE_SAW: begin
                    if (duty_q > peak) begin
                        duty_d = peak;
                    end else if (duty_q == peak) begin
                        duty_d = ZERO;
                    end else begin
                        duty_d = duty_q + ONE;
                    end
                end
                MODE_TRI: begin
                    if (peak == ZERO) begin
                        duty_d = ZERO;
                        dir_d  = DIR_UP;
                    end else if (duty_q > peak) begin
                        duty_d = peak;
                        dir_d  = DIR_DOWN;
                    end else if (dir_cur == DIR_UP) begin
                        if (duty_q == peak) begin
                            duty_d = duty_q - ONE;
                            dir_d  = DIR_DOWN;
                        end else begin
                            duty_d = duty_q + ONE;
                            if (duty_q == peak - ONE) dir_d = DIR_DOWN;
                        end
                    end else begin
                        if (duty_q == ZERO) begin
                            duty_d = ONE;
                            dir_d  = DIR_UP;
                        end else begin
                            duty_d = duty_q - ONE;
                            if (duty_q == ONE) dir_d = DIR_UP;
                        end
                    end
                end
                MODE_HOLD: duty_d = peak;
            endcase
        end
        if (en && cnt == CNT_MAX) begin
            shadow_d = duty_q;
        end
        led_d = en ? ((cnt < shadow_q) ^ ACTIVE_LOW) : ACTIVE_LOW;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            duty_q   <= '0;
            shadow_q <= '0;
            dir_q    <= DIR_UP;
            mode_q   <= MODE_OFF;
            led_q    <= ACTIVE_LOW;
        end else begin
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            led_q    <= led_d;
        end
    end

    assign duty = duty_q;
    assign led  = led_q;

endmodule

// File: rtl/pwm_breathe.sv
// Multi-channel breathing LED driver: shared PWM counter and
// ramp-step prescaler feeding one pwm_channel per LED.
module pwm_breathe
    import pwm_breathe_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 262144,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      en,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [WIDTH-1:0]          peak,
    output logic [CHANNELS-1:0]       LED,
    output logic [CHANNELS*WIDTH-1:0] duty,
    output logic                      step
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             step_w;

    always_comb begin
        step_w = en && (pre_q == PRE_LAST);
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
            pre_d = step_w ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            pre_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
        end
    end

    assign step = step_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH      (WIDTH),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .CLK   (CLK),
            .RST_N (RST_N),
            .en    (en),
            .step  (step_w),
            .cnt   (cnt_q),
            .mode  (mode[2*i +: 2]),
            .peak  (peak),
            .duty  (duty[i*WIDTH +: WIDTH]),
            .led   (LED[i])
        );
    end

endmodule

// File: tb/tb_pwm_breathe.sv
// Directed bench for pwm_breathe with WIDTH=4, PRESCALE=4,
// CHANNELS=2, ACTIVE_LOW=1.
module tb_pwm_breathe;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       en;
    logic [3:0] mode;
    logic [3:0] peak;
    logic [1:0] LED;
    logic [7:0] duty;
    logic       step;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_breathe #(
        .CHANNELS   (2),
        .WIDTH      (4),
        .PRESCALE   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (en),
        .mode  (mode),
        .peak  (peak),
        .LED   (LED),
        .duty  (duty),
        .step  (step)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] mode;
        logic [3:0] peak;
        logic [3:0] d0;
        logic [3:0] d1;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_step(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge CLK);
            if (step === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: step timeout got 0 expected 1", name);
        end
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input logic [3:0] m, input logic [3:0] p,
                                input logic [3:0] a, input logic [3:0] b);
        vec_t v;
        v.mode = m;
        v.peak = p;
        v.d0   = a;
        v.d1   = b;
        return v;
    endfunction

    initial begin
        int lo1;
        int lo2;
        int bad;

        // mode = {ch1, ch0}: OFF=0 SAW=1 TRI=2 HOLD=3
        vecs[0]  = mk(4'b0000, 4'd3, 4'd0, 4'd0);
        vecs[1]  = mk(4'b0110, 4'd3, 4'd1, 4'd1);
        vecs[2]  = mk(4'b0110, 4'd3, 4'd2, 4'd2);
        vecs[3]  = mk(4'b0110, 4'd3, 4'd3, 4'd3);
        vecs[4]  = mk(4'b0110, 4'd3, 4'd2, 4'd0);
        vecs[5]  = mk(4'b0110, 4'd3, 4'd1, 4'd1);
        vecs[6]  = mk(4'b0110, 4'd3, 4'd0, 4'd2);
        vecs[7]  = mk(4'b0110, 4'd3, 4'd1, 4'd3);
        vecs[8]  = mk(4'b0010, 4'd10, 4'd2, 4'd0);
        vecs[9]  = mk(4'b0010, 4'd10, 4'd3, 4'd0);
        vecs[10] = mk(4'b0010, 4'd10, 4'd4, 4'd0);
        vecs[11] = mk(4'b0010, 4'd10, 4'd5, 4'd0);
        vecs[12] = mk(4'b0010, 4'd10, 4'd6, 4'd0);
        vecs[13] = mk(4'b0010, 4'd10, 4'd7, 4'd0);
        vecs[14] = mk(4'b0010, 4'd10, 4'd8, 4'd0);
        vecs[15] = mk(4'b0010, 4'd10, 4'd9, 4'd0);
        vecs[16] = mk(4'b0010, 4'd4, 4'd4, 4'd0);
        vecs[17] = mk(4'b0010, 4'd4, 4'd3, 4'd0);
        vecs[18] = mk(4'b0110, 4'd0, 4'd0, 4'd0);
        vecs[19] = mk(4'b1101, 4'd0, 4'd0, 4'd0);
        vecs[20] = mk(4'b1101, 4'd5, 4'd1, 4'd5);
        vecs[21] = mk(4'b1101, 4'd5, 4'd2, 4'd5);

        RST_N = 1'b0;
        en    = 1'b1;
        mode  = 4'b0011;
        peak  = 4'd8;
        @(negedge CLK);
        @(negedge CLK);
        check("reset_led", LED, 2'b11);
        check("reset_duty", duty, 8'h00);
        check("reset_step", step, 1'b0);

        RST_N = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            check($sformatf("first_step_c%0d", k), step, (k == 3));
        end
        check("hold_duty", duty[3:0], 4'd8);

        repeat (12) @(negedge CLK);
        check("hold_old_period", LED, 2'b11);
        lo1 = 0;
        for (int k = 17; k <= 32; k++) begin
            @(negedge CLK);
            if (k == 17) check("hold_first_low", LED, 2'b10);
            if (LED[0] == 1'b0) lo1++;
        end
        check("hold_low_count", lo1, 8);

        for (int i = 0; i < 22; i++) begin
            mode = vecs[i].mode;
            peak = vecs[i].peak;
            wait_step($sformatf("vec%0d", i));
            check($sformatf("vec%0d_d0", i), duty[3:0], vecs[i].d0);
            check($sformatf("vec%0d_d1", i), duty[7:4], vecs[i].d1);
        end

        // Asynchronous reset in the middle of a period.
        #3;
        RST_N = 1'b0;
        #1;
        check("midrst_led", LED, 2'b11);
        check("midrst_duty", duty, 8'h00);
        check("midrst_step", step, 1'b0);
        mode = 4'b0011;
        peak = 4'd6;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        lo1 = 0;
        lo2 = 0;
        for (int t = 1; t <= 48; t++) begin
            @(negedge CLK);
            if (t == 4)  check("shadow_duty6", duty[3:0], 4'd6);
            if (t == 21) peak = 4'd12;
            if (t == 24) check("shadow_duty12", duty[3:0], 4'd12);
            if (t == 33) mode = 4'b0111;
            if (t >= 17 && t <= 32 && LED[0] == 1'b0) lo1++;
            if (t >= 33 && LED[0] == 1'b0) lo2++;
            if (t == 48) check("saw_pre_freeze", duty[7:4], 4'd4);
        end
        check("shadow_keep_width", lo1, 6);
        check("shadow_new_width", lo2, 12);

        @(negedge CLK);
        @(negedge CLK);
        check("pre_en_led", LED, 2'b00);
        en = 1'b0;
        bad = 0;
        for (int t = 51; t <= 70; t++) begin
            @(negedge CLK);
            if (t == 51) check("en_off_led", LED, 2'b11);
            if (LED !== 2'b11 || step !== 1'b0) bad++;
        end
        check("en_off_cycles", bad, 0);
        check("en_off_duty", duty, 8'h4C);
        en = 1'b1;
        @(negedge CLK);
        check("resume_step", step, 1'b1);
        check("resume_led", LED, 2'b00);
        @(negedge CLK);
        check("resume_duty", duty, 8'h5C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
